// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared types and configuration helpers for the calculator
//             datapath (flag bundle, pipeline depth derivation, config check).
//  Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // Flag bundle registered alongside every ALU result.
  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  // Number of pipeline stages: one per CHUNK-bit slice of the operands.
  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal configuration: at least two bits wide, whole number of chunks.
  function automatic bit calc_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= 2) && ((width % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_chunk
//  Purpose  : Combinational CHUNK-bit adder slice. Produces the slice sum,
//             the carry out of the slice and the carry into its top bit.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] total;

  // Slice addition; the carry into the top bit is recovered from the
  // top-bit sum equation so the slice works for any CHUNK >= 1.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum   = total[CHUNK-1:0];
    cout  = total[CHUNK];
    cmsb  = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pipe
//  Purpose  : WIDTH-bit pipelined adder/subtractor, CHUNK bits resolved per
//             stage, with carry/borrow-in, full flag set and valid/ready
//             handshake on both sides (global-stall, no skid buffer).
//  Revision : 1.0  initial release
// ============================================================================
module addsub_pipe
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!calc_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + ~borrow; the whole pipe moves when the output
  // slot is empty or being drained.
  always_comb begin
    adv   = ~out_valid | out_ready;
    b_eff = sub ? ~b : b;
    c0    = sub ? ~cin : cin;
  end

  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be processed at this stage, and the partial
    // sum width accumulated once this stage has registered.
    localparam int OPW = WIDTH - k * CHUNK;
    localparam int SW  = (k + 1) * CHUNK;

    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic             c_in;
    logic [CHUNK-1:0] sum_w;
    logic             cout_w;
    logic             cmsb_w;
    logic             valid_d;
    logic             valid_q;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;

    if (k == 0) begin : g_head
      // First stage works directly on the conditioned inputs.
      always_comb begin
        op_a    = a;
        op_b    = b_eff;
        c_in    = c0;
        valid_d = in_valid;
        sum_d   = sum_w;
      end
    end else begin : g_body
      // Later stages pick up the travelling operands, carry and partial sum.
      always_comb begin
        op_a    = g_stage[k-1].g_fwd.a_q;
        op_b    = g_stage[k-1].g_fwd.b_q;
        c_in    = g_stage[k-1].g_fwd.carry_q;
        valid_d = g_stage[k-1].valid_q;
        sum_d   = {sum_w, g_stage[k-1].sum_q};
      end
    end

    addsub_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .cin  (c_in),
      .a    (op_a[CHUNK-1:0]),
      .b    (op_b[CHUNK-1:0]),
      .sum  (sum_w),
      .cout (cout_w),
      .cmsb (cmsb_w)
    );

    // Stage valid and partial sum: shift on advance, hold (bubbles too) on stall.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int RW = OPW - CHUNK;

      logic [RW-1:0] a_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_d;
      logic [RW-1:0] b_q;
      logic          carry_d;
      logic          carry_q;
      logic          cmsb_unused;

      // Only the final slice's carry into the MSB feeds the overflow flag.
      assign cmsb_unused = cmsb_w;

      // Unprocessed upper operand bits and the slice carry move to the next stage.
      always_comb begin
        a_d     = op_a[OPW-1:CHUNK];
        b_d     = op_b[OPW-1:CHUNK];
        carry_d = cout_w;
      end

      // Forwarded operand/carry register, same advance rule as the stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q     <= '0;
          b_q     <= '0;
          carry_q <= 1'b0;
        end else if (adv) begin
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= carry_d;
        end
      end
    end
  end

  alu_flags_t flags_d;
  alu_flags_t flags_q;

  // Flags come from the final slice before registration so they are
  // captured in the same edge as the result itself.
  always_comb begin
    flags_d.cout     = g_stage[STAGES-1].cout_w;
    flags_d.overflow = g_stage[STAGES-1].cmsb_w ^ g_stage[STAGES-1].cout_w;
    flags_d.zero     = ~|g_stage[STAGES-1].sum_d;
    flags_d.negative = g_stage[STAGES-1].sum_d[WIDTH-1];
  end

  // Flag register tracks the final stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (adv) begin
      flags_q <= flags_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign f         = g_stage[STAGES-1].sum_q;
  assign cout      = flags_q.cout;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_pipe
//  Purpose  : Directed self-checking bench for addsub_pipe (WIDTH=16,
//             CHUNK=4): flag corner cases, streaming, stall and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         negative;

  logic [19:0]  res;
  int           checks = 0;
  int           errors = 0;

  assign res = {f, cout, overflow, zero, negative};

  always #5 clk = ~clk;

  addsub_pipe #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic, {f, cout, overflow, zero, negative}.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    int          sx, sy, sr, ur;
    logic [15:0] r;
    logic        co, v;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      sr = sx - sy - int'(c);
      ur = int'(x) - int'(y) - int'(c);
      co = (ur >= 0);
    end else begin
      sr = sx + sy + int'(c);
      ur = int'(x) + int'(y) + int'(c);
      co = (ur > 65535);
    end
    r = ur[15:0];
    v = (sr > 32767) || (sr < -32768);
    return {r, co, v, (r == 16'h0000), r[15]};
  endfunction

  // One isolated operation: checks latency (not out after 3 edges, out after 4).
  task automatic run_one(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic c, input logic [19:0] exp);
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk(name, 32'(res), 32'(exp));
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vs [8];
  logic        vc [8];
  logic [19:0] ve [8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'(res), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Flag corner cases, hand-computed
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 20'h80005);
    run_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 20'h0000A);
    run_one("sub_borrow",16'h0000, 16'h0001, 1'b1, 1'b0, 20'hFFFF1);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 20'h7FFFC);
    run_one("sub_bin",   16'h0005, 16'h0003, 1'b1, 1'b1, 20'h00018);
    run_one("add_cin",   16'h1234, 16'h0F0F, 1'b0, 1'b1, 20'h21440);
    tick();

    // Streaming: 8 back-to-back operations, results from cycle 4 onward
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vs[i] = 1'($urandom);
      vc[i] = 1'($urandom);
      ve[i] = model(va[i], vb[i], vs[i], vc[i]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      if (c < 8) begin
        a = va[c]; b = vb[c]; sub = vs[c]; cin = vc[c];
      end
      tick();
      chk($sformatf("stream_valid%0d", c), 32'(out_valid), 32'((c >= 3) && (c <= 10)));
      if ((c >= 3) && (c <= 10)) begin
        chk($sformatf("stream_res%0d", c - 3), 32'(res), 32'(ve[c-3]));
      end
    end

    // Stall: fill with 4, hold output for 3 cycles while op 4 waits
    for (int i = 0; i < 5; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vs[i] = 1'($urandom);
      vc[i] = 1'($urandom);
      ve[i] = model(va[i], vb[i], vs[i], vc[i]);
    end
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = va[c]; b = vb[c]; sub = vs[c]; cin = vc[c];
      tick();
    end
    chk("stall_first_valid", 32'(out_valid), 32'd1);
    chk("stall_first_res", 32'(res), 32'(ve[0]));
    a = va[4]; b = vb[4]; sub = vs[4]; cin = vc[4];
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b0;
      #1;
      chk($sformatf("stall_in_ready%0d", c), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("stall_hold_valid%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall_hold_res%0d", c), 32'(res), 32'(ve[0]));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int j = 1; j < 5; j++) begin
      chk($sformatf("release_valid%0d", j), 32'(out_valid), 32'd1);
      chk($sformatf("release_res%0d", j), 32'(res), 32'(ve[j]));
      tick();
    end
    chk("release_drained", 32'(out_valid), 32'd0);

    // Reset mid-flight: one result stalled, three in the pipe
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = va[c]; b = vb[c]; sub = vs[c]; cin = vc[c];
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("mid_stalled_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_outputs", 32'(res), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("mid_no_stale%0d", c), 32'(out_valid), 32'd0);
    end
    run_one("post_rst", 16'h1234, 16'h0F0F, 1'b0, 1'b1, 20'h21440);
    tick();
    chk("post_rst_drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined adder/subtractor for the calculator datapath. It replaces the fixed 8-bit single-cycle ripple adder with a WIDTH-bit unit that processes CHUNK bits per pipeline stage. It adds subtract/borrow mode, a full flag set and a valid/ready handshake on both sides. It sits between the register-bank read ports and the write-back path.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits resolved per pipeline stage; the number of stages is STAGES = WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operand set is presented.
- in_ready  out  1  the pipeline accepts the operand set this cycle.
- a, b  in  WIDTH  operands.
- sub  in  1  0 = a+b+cin; 1 = a−b−cin, with cin acting as borrow-in.
- cin  in  1  carry-in (add) or borrow-in (sub).
- out_valid  out  1  a result is present.
- out_ready  in  1  the consumer takes the result this cycle.
- f  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB; in sub mode 1 means no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  f == 0.
- negative  out  1  f[WIDTH-1].

## Operation
- Effective operation is a + b' + c0, where b' = sub ? ~b : b and c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1) adds bits [k·CHUNK +: CHUNK] of a and b' with the carry registered by stage k−1; stage 0 uses c0.
- Each stage registers its partial sum, its carry and the not-yet-processed upper operand bits, which travel with the transaction.
- The last stage produces f, cout and the flags:
  - overflow = carry into the MSB XOR carry out of the MSB.
  - zero = ~|f.
  - negative = f[WIDTH-1].
- Flags are registered together with f; they are never computed combinationally from the output registers.
- Flow control: a global advance signal adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv = 1 every stage register shifts by one and each stage valid bit takes the previous stage's valid bit; stage 0 takes in_valid.
  - When adv = 0 all stages hold, including bubbles. The pipeline has no skid buffer.
- A transfer happens on a side only when valid & ready are both 1 in the same cycle.
- Transaction ordering is strictly preserved; there is no reordering and no drop.

## Timing
- Latency: an operand set accepted at edge n appears with out_valid = 1 after edge n+STAGES, assuming no stalls.
- Throughput: one result per cycle while out_ready = 1.
- in_ready is a combinational function of out_valid and out_ready only; it never depends on in_valid.
- out_valid, f and the flags come straight from registers. While out_valid = 1 and out_ready = 0 they must stay stable.
- Simultaneous output take and input accept in the same cycle are both honoured; the pipeline stays full.
- Reset (asynchronous, any time, including mid-stall or mid-flight):
  - All valid bits clear immediately and out_valid = 0.
  - f, cout, overflow, zero and negative read 0.
  - In-flight transactions are discarded.
  - in_ready is 1 as soon as rst is released.
- STAGES = 1 degenerates to a single registered stage with latency 1.

## Structure
- Shared package calc_pkg holds:
  - an alu_flags_t struct {cout, overflow, zero, negative};
  - the localparam STAGES derivation;
  - a WIDTH % CHUNK == 0 elaboration check.
- One sub-module, addsub_chunk: combinational CHUNK-bit adder with {carry-in, a, b'} → {sum, carry-out, carry into MSB}. It is instantiated STAGES times by generate; only the last instance's carry into MSB is used.
- Pipeline registers and handshake live in addsub_pipe.

## Test plan
All scenarios use WIDTH = 16 and CHUNK = 4, so latency is 4.
- Add overflow: 0x7FFF + 0x0001, sub = 0, cin = 0 → after 4 cycles f = 0x8000, cout = 0, overflow = 1, negative = 1, zero = 0.
- Add wrap to zero: 0xFFFF + 0x0001 → f = 0x0000, cout = 1, zero = 1, overflow = 0, negative = 0.
- Subtract with borrow:
  - 0x0000 − 0x0001, cin = 0 → f = 0xFFFF, cout = 0, overflow = 0, negative = 1.
  - 0x8000 − 0x0001 → f = 0x7FFF, overflow = 1.
  - 0x0005 − 0x0003 with cin = 1 → f = 0x0001, cout = 1.
- Streaming and stall: 8 back-to-back random operations with out_ready = 1 → 8 consecutive results in order from cycle 4 onward, matching the reference model. Then hold out_ready = 0 for 3 cycles → in_ready = 0, f and flags stable, no loss on release.
- Reset mid-flight: assert rst with 3 operations in the pipeline and one result stalled → out_valid = 0 and all outputs = 0 immediately, no stale result after release, the next operation emerges exactly 4 cycles after it is accepted.
